// File: rtl/i2s_receiver.sv
// I2S deserialiser: oversamples asynchronous BCLK/WCLK/DATA in the clk_in domain
// and presents complete stereo frames with a strobe, lock flag and slot error strobe.
module i2s_receiver #(
  parameter int BITS     = 16,
  parameter bit INV_BCLK = 1'b0
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            I2S_BCLK,
  input  logic            I2S_WCLK,
  input  logic            I2S_DATA,
  output logic [BITS-1:0] ADC_Left,
  output logic [BITS-1:0] ADC_Right,
  output logic            sample_pulse,
  output logic            locked,
  output logic            frame_error
);

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

  localparam logic [5:0] BITS_W = 6'(BITS);

  logic bclk_s1_q, bclk_s2_q, bclk_h_q;
  logic ws_s1_q, ws_s2_q, dat_s1_q, dat_s2_q;
  logic edge_d, edge_q, ws_e_q, dat_e_q;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic            ws_prev_q, ws_prev_d;
  logic            have_prev_q, have_prev_d;
  logic [BITS-1:0] left_hold_q, left_hold_d;
  logic            left_ok_q, left_ok_d;
  logic [BITS-1:0] adc_l_q, adc_l_d, adc_r_q, adc_r_d;
  logic            locked_q, locked_d;
  logic            pulse_q, pulse_d;
  logic            ferr_q, ferr_d;
  logic            ws_change, slot_good;

  assign ADC_Left     = adc_l_q;
  assign ADC_Right    = adc_r_q;
  assign sample_pulse = pulse_q;
  assign locked       = locked_q;
  assign frame_error  = ferr_q;

  // The first edge after reset only seeds ws_prev, so a slot cut by reset never closes as a ws edge.
  assign ws_change = have_prev_q && (ws_e_q != ws_prev_q);
  assign slot_good = (cnt_q >= BITS_W) && (cnt_q <= 6'd32);

  always_comb begin
    edge_d      = INV_BCLK ? (!bclk_s2_q && bclk_h_q) : (bclk_s2_q && !bclk_h_q);
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ws_prev_d   = ws_prev_q;
    have_prev_d = have_prev_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    adc_l_d     = adc_l_q;
    adc_r_d     = adc_r_q;
    locked_d    = locked_q;
    pulse_d     = 1'b0;
    ferr_d      = 1'b0;
    if (edge_q) begin
      ws_prev_d   = ws_e_q;
      have_prev_d = 1'b1;
      if (!ws_change) begin
        if (cnt_q < BITS_W) shift_d = {shift_q[BITS-2:0], dat_e_q};
        if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
      end else begin
        cnt_d   = 6'd0;
        shift_d = '0;
        case (state_q)
          HUNT: begin
            left_ok_d = 1'b0;
            state_d   = ws_e_q ? RIGHT : LEFT;
          end
          LEFT: begin
            left_hold_d = shift_q;
            left_ok_d   = slot_good;
            if (!slot_good) begin
              ferr_d   = 1'b1;
              locked_d = 1'b0;
            end
            state_d = RIGHT;
          end
          default: begin
            // A right slot only produces output when the left slot before it was good.
            if (!slot_good) begin
              ferr_d   = 1'b1;
              locked_d = 1'b0;
            end else if (left_ok_q) begin
              adc_l_d  = left_hold_q;
              adc_r_d  = shift_q;
              pulse_d  = 1'b1;
              locked_d = 1'b1;
            end
            left_ok_d = 1'b0;
            state_d   = LEFT;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_h_q    <= 1'b0;
      ws_s1_q     <= 1'b0;
      ws_s2_q     <= 1'b0;
      dat_s1_q    <= 1'b0;
      dat_s2_q    <= 1'b0;
      edge_q      <= 1'b0;
      ws_e_q      <= 1'b0;
      dat_e_q     <= 1'b0;
      state_q     <= HUNT;
      cnt_q       <= 6'd0;
      shift_q     <= '0;
      ws_prev_q   <= 1'b0;
      have_prev_q <= 1'b0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      adc_l_q     <= '0;
      adc_r_q     <= '0;
      locked_q    <= 1'b0;
      pulse_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      bclk_s1_q   <= I2S_BCLK;
      bclk_s2_q   <= bclk_s1_q;
      bclk_h_q    <= bclk_s2_q;
      ws_s1_q     <= I2S_WCLK;
      ws_s2_q     <= ws_s1_q;
      dat_s1_q    <= I2S_DATA;
      dat_s2_q    <= dat_s1_q;
      // WCLK/DATA are captured alongside the edge so they match the pin values at the BCLK edge.
      edge_q      <= edge_d;
      ws_e_q      <= ws_s2_q;
      dat_e_q     <= dat_s2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ws_prev_q   <= ws_prev_d;
      have_prev_q <= have_prev_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      adc_l_q     <= adc_l_d;
      adc_r_q     <= adc_r_d;
      locked_q    <= locked_d;
      pulse_q     <= pulse_d;
      ferr_q      <= ferr_d;
    end
  end

endmodule
